fetch_resp: RTL

FETCH_RESP -- requirements
Module: fetch_resp

---
 rtl/fetch_resp.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_resp.sv
// Instruction fetch responder: program-loadable word memory answered over a four-phase req/ack handshake.
// Optional per-word even-parity checking is enabled by defining SISC_FETCH_PARITY_EN.
module fetch_resp #(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              busy,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_perr,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       mem [DEPTH];
    logic              par_err_in;
    logic              par_err_lat;

    // Memory is never reset so a program survives a mid-fetch reset.
    always_ff @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
    end

`ifdef SISC_FETCH_PARITY_EN
    logic mem_par [DEPTH];

    always_ff @(posedge clk) begin
        if (ld_we) mem_par[ld_addr] <= (^ld_data) ^ ld_perr;
    end

    assign par_err_in  = (^mem[addr]) ^ mem_par[addr];
    assign par_err_lat = (^mem[lat_addr]) ^ mem_par[lat_addr];
`else
    logic perr_unused;
    assign perr_unused = ld_perr;
    assign par_err_in  = 1'b0;
    assign par_err_lat = 1'b0;
`endif

    // Memory reads use pre-edge contents, so a load on the RESP-entry edge returns old data.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lat_addr <= '0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            rdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_addr <= addr;
                        busy     <= 1'b1;
                        if (WAIT_CYC == 0) begin
                            state <= RESP;
                            cnt   <= 4'd0;
                            ack   <= 1'b1;
                            rdata <= mem[addr];
                            err   <= par_err_in;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        state <= RESP;
                        cnt   <= 4'd0;
                        ack   <= 1'b1;
                        rdata <= mem[lat_addr];
                        err   <= par_err_lat;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (!req) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
